// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared defaults, zero-register constant and write-count helper
package cpu_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int ZERO_REG  = 0;

   // Upper bounds for the packed arguments of unique_write_count
   localparam int MAX_NWR = 8;
   localparam int MAX_AW  = 16;

   // Count distinct nonzero addresses written this cycle; a port is counted only
   // if no higher-index enabled port targets the same address.
   function automatic logic [31:0] unique_write_count(
      input int                          n,
      input logic [MAX_NWR-1:0]          we,
      input logic [MAX_NWR*MAX_AW-1:0]   wa
   );
      logic [31:0]       cnt;
      logic [MAX_AW-1:0] ai;
      logic [MAX_AW-1:0] aj;
      logic              dup;
      cnt = '0;
      for (int i = 0; i < MAX_NWR; i++) begin
         ai = wa[i*MAX_AW +: MAX_AW];
         if (i < n && we[i] && ai != '0) begin
            dup = 1'b0;
            for (int j = i + 1; j < MAX_NWR; j++) begin
               aj = wa[j*MAX_AW +: MAX_AW];
               if (j < n && we[j] && aj == ai) dup = 1'b1;
            end
            if (!dup) cnt = cnt + 32'd1;
         end
      end
      return cnt;
   endfunction

endpackage

// File: rtl/cpu_scoreboard.sv
// rtl/cpu_scoreboard.sv - per-register pending-producer tracking with clear bypass
module cpu_scoreboard
   import cpu_pkg::*;
#(
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = 2,
   parameter int NWR   = 2,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NRD*AW-1:0] ra,
   input  logic [NWR-1:0]    we,
   input  logic [NWR*AW-1:0] wa,
   input  logic [NWR-1:0]    wclr,
   input  logic              iss_v,
   input  logic [AW-1:0]     iss_rd,
   input  logic              flush,
   output logic [NRD-1:0]    rbusy,
   output logic              any_busy
);

   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nxt;
   logic [NREGS-1:0] clr_vec;
   logic [AW-1:0]    rsel;

   // Registers being retired by a clearing writeback this cycle
   always_comb begin
      clr_vec = '0;
      for (int i = 0; i < NWR; i++)
         if (we[i] && wclr[i]) clr_vec[wa[i*AW +: AW]] = 1'b1;
      clr_vec[ZERO_REG] = 1'b0;
   end

   // Next busy state: flush, then issue (newer producer wins), then clear, else hold
   always_comb begin
      busy_nxt = busy;
      for (int a = 1; a < NREGS; a++) begin
         if (flush)
            busy_nxt[a] = 1'b0;
         else if (iss_v && iss_rd == AW'(a))
            busy_nxt[a] = 1'b1;
         else if (clr_vec[a])
            busy_nxt[a] = 1'b0;
      end
      busy_nxt[ZERO_REG] = 1'b0;
   end

   // Per-port busy, masked by a same-cycle clear so the consumer can proceed
   always_comb begin
      rbusy = '0;
      rsel  = '0;
      for (int j = 0; j < NRD; j++) begin
         rsel     = ra[j*AW +: AW];
         rbusy[j] = busy[rsel] & ~clr_vec[rsel] & (rsel != AW'(ZERO_REG));
      end
   end

   assign any_busy = |busy;

   // Busy vector register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy <= '0;
      else     busy <= busy_nxt;
   end

endmodule

// File: rtl/cpu_regfile_sb.sv
// rtl/cpu_regfile_sb.sv - multi-port register file with write bypass and scoreboard
module cpu_regfile_sb
   import cpu_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = 2,
   parameter int NWR   = 2,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   ra,
   output logic [NRD*XLEN-1:0] rd,
   output logic [NRD-1:0]      rbusy,
   input  logic [NWR-1:0]      we,
   input  logic [NWR*AW-1:0]   wa,
   input  logic [NWR*XLEN-1:0] wd,
   input  logic [NWR-1:0]      wclr,
   input  logic                iss_v,
   input  logic [AW-1:0]       iss_rd,
   input  logic                flush,
   output logic                any_busy,
   output logic [31:0]         wr_count
);

   logic [XLEN-1:0]           mem  [NREGS];
   logic [XLEN-1:0]           wdat [NREGS];
   logic [NREGS-1:0]          wen_vec;
   logic [AW-1:0]             rsel;
   logic [MAX_NWR-1:0]        we_pad;
   logic [MAX_NWR*MAX_AW-1:0] wa_pad;
   logic [31:0]               wr_inc;

   // Per-register write enable and data; later (higher) ports override earlier ones
   always_comb begin
      wen_vec = '0;
      for (int a = 0; a < NREGS; a++) wdat[a] = '0;
      for (int i = 0; i < NWR; i++) begin
         if (we[i]) begin
            wen_vec[wa[i*AW +: AW]] = 1'b1;
            wdat[wa[i*AW +: AW]]    = wd[i*XLEN +: XLEN];
         end
      end
      wen_vec[ZERO_REG] = 1'b0;
   end

   // Combinational read with same-cycle bypass; x0 and reset force zero
   always_comb begin
      rd   = '0;
      rsel = '0;
      for (int j = 0; j < NRD; j++) begin
         rsel = ra[j*AW +: AW];
         if (!rst && rsel != AW'(ZERO_REG))
            rd[j*XLEN +: XLEN] = wen_vec[rsel] ? wdat[rsel] : mem[rsel];
      end
   end

   // Widen write ports into the fixed-stride layout the count helper expects
   always_comb begin
      we_pad = '0;
      wa_pad = '0;
      for (int i = 0; i < NWR; i++) begin
         we_pad[i]                   = we[i];
         wa_pad[i*MAX_AW +: MAX_AW]  = MAX_AW'(wa[i*AW +: AW]);
      end
      wr_inc = unique_write_count(NWR, we_pad, wa_pad);
   end

   // Storage and committed-write counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int a = 0; a < NREGS; a++) mem[a] <= '0;
         wr_count <= '0;
      end else begin
         for (int a = 1; a < NREGS; a++)
            if (wen_vec[a]) mem[a] <= wdat[a];
         wr_count <= wr_count + wr_inc;
      end
   end

   cpu_scoreboard #(
      .NREGS (NREGS),
      .NRD   (NRD),
      .NWR   (NWR),
      .AW    (AW)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .ra       (ra),
      .we       (we),
      .wa       (wa),
      .wclr     (wclr),
      .iss_v    (iss_v),
      .iss_rd   (iss_rd),
      .flush    (flush),
      .rbusy    (rbusy),
      .any_busy (any_busy)
   );

endmodule
